// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: header field positions, arbiter states and beat-count helper for eth_tx_frame_arbiter
package eth_tx_pkg;
    localparam int HDR_SIZE_LSB = 0;
    localparam int HDR_SIZE_MSB = 15;
    localparam int HDR_OFF_LSB  = 16;
    localparam int HDR_OFF_MSB  = 18;
    typedef enum logic [1:0] {IDLE, HDR, PAY, DRAIN} eth_tx_arb_state_e;
    // 64-bit beats needed to cover size bytes starting at byte offset off
    function automatic logic [13:0] beat_count(input logic [15:0] size, input logic [2:0] off);
        logic [16:0] w_sum;
        w_sum = 17'(size) + 17'(off) + 17'd7;
        return w_sum[16:3];
    endfunction
endpackage

// File: rtl/eth_tx_rr_arb.sv
// eth_tx_rr_arb: round-robin one-hot grant; priority starts just after the last owner
//  clk_i, reset_n_i : clock, async active-low reset (pointer -> 0)
//  req_i            : request vector
//  adv_i            : frame finished, move pointer past owner_i
//  owner_i          : one-hot owner of the finishing frame
//  grant_o          : combinational one-hot winner for the current requests
module eth_tx_rr_arb #(
    parameter int num_req_p = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [num_req_p-1:0] req_i,
    input  logic                 adv_i,
    input  logic [num_req_p-1:0] owner_i,
    output logic [num_req_p-1:0] grant_o
);
    localparam int PW = $clog2(num_req_p);
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_owner_idx;
    logic          w_found;
    // two passes: indices at/after the pointer, then the wrapped-around ones
    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (!w_found && req_i[i] && i >= int'(r_ptr)) begin
                grant_o[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
        for (int i = 0; i < num_req_p; i++) begin
            if (!w_found && req_i[i] && i < int'(r_ptr)) begin
                grant_o[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end
    always_comb begin
        w_owner_idx = '0;
        for (int i = 0; i < num_req_p; i++)
            if (owner_i[i]) w_owner_idx = PW'(i);
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_ptr <= '0;
        else if (adv_i) r_ptr <= (w_owner_idx == PW'(num_req_p - 1)) ? '0 : w_owner_idx + 1'b1;
    end
endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: whole-frame round-robin sharing of the TX frame port, drops empty/oversize frames
//  clk_i, reset_n_i  : clock, async active-low reset
//  req_data_i/v_i    : per-requester words (requester i at [64*i +: 64]) and valid
//  req_yumi_o        : per-requester word consumed (owner only)
//  frame_data_o/v_o  : zero-latency word to the TX converter, frame_data_yumi_i consumes it
//  grant_o, busy_o   : current owner (one-hot, 0 in IDLE), state != IDLE
//  drop_o            : 1-cycle pulse when a frame is discarded
//  ETH_TX_ARB_STATS_EN adds frames_sent_o (32 bits per requester) and frames_dropped_o, saturating
module eth_tx_frame_arbiter
    import eth_tx_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int max_frame_bytes_p = 1522
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [num_req_p*64-1:0] req_data_i,
    input  logic [num_req_p-1:0]    req_v_i,
    output logic [num_req_p-1:0]    req_yumi_o,
    output logic [63:0]             frame_data_o,
    output logic                    frame_data_v_o,
    input  logic                    frame_data_yumi_i,
    output logic [num_req_p-1:0]    grant_o,
    output logic                    busy_o,
    output logic                    drop_o
`ifdef ETH_TX_ARB_STATS_EN
    ,
    output logic [num_req_p*32-1:0] frames_sent_o,
    output logic [31:0]             frames_dropped_o
`endif
);
    localparam logic [15:0] MAX_SIZE = 16'(max_frame_bytes_p);
    eth_tx_arb_state_e    r_state;
    logic [num_req_p-1:0] r_grant;
    logic [13:0]          r_cnt;
    logic [num_req_p-1:0] w_arb_grant;
    logic [63:0]          w_own_data;
    logic [15:0]          w_size;
    logic                 w_own_v, w_zero, w_big, w_last, w_take, w_sent, w_adv, w_local;
    always_comb begin
        w_own_data = '0;
        for (int i = 0; i < num_req_p; i++)
            if (r_grant[i]) w_own_data = req_data_i[64*i +: 64];
    end
    assign w_own_v = |(req_v_i & r_grant);
    assign w_size  = w_own_data[HDR_SIZE_MSB:HDR_SIZE_LSB];
    assign w_zero  = w_size == 16'd0;
    assign w_big   = w_size > MAX_SIZE;
    assign w_last  = r_cnt == 14'd1;
    // words the arbiter swallows itself: bad headers and drained payload
    assign w_local = (r_state == HDR && (w_zero || w_big)) || r_state == DRAIN;
    always_comb begin
        frame_data_v_o = w_own_v && ((r_state == HDR && !w_zero && !w_big) || r_state == PAY);
        frame_data_o   = (r_state == HDR || r_state == PAY) ? w_own_data : '0;
        w_take         = w_local ? w_own_v : frame_data_v_o && frame_data_yumi_i;
        req_yumi_o     = r_grant & {num_req_p{w_take}};
        drop_o         = w_own_v && ((r_state == HDR && w_zero) || (r_state == DRAIN && w_last));
        w_sent         = w_take && r_state == PAY && w_last;
        w_adv          = drop_o || w_sent;
    end
    assign grant_o = r_grant;
    assign busy_o  = r_state != IDLE;
    eth_tx_rr_arb #(.num_req_p(num_req_p)) u_arb (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .req_i    (req_v_i),
        .adv_i    (w_adv),
        .owner_i  (r_grant),
        .grant_o  (w_arb_grant)
    );
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (|req_v_i) begin
                    r_grant <= w_arb_grant;
                    r_state <= HDR;
                end
                HDR: if (w_take) begin
                    r_cnt   <= beat_count(w_size, w_own_data[HDR_OFF_MSB:HDR_OFF_LSB]);
                    r_state <= w_zero ? IDLE : w_big ? DRAIN : PAY;
                    r_grant <= w_zero ? '0 : r_grant;
                end
                default: if (w_take) begin
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end
                end
            endcase
        end
    end
`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] r_sent [num_req_p];
    logic [31:0] r_dropped;
    for (genvar i = 0; i < num_req_p; i++) begin : g_sent
        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) r_sent[i] <= '0;
            else if (w_sent && r_grant[i] && r_sent[i] != '1) r_sent[i] <= r_sent[i] + 1'b1;
        end
        assign frames_sent_o[32*i +: 32] = r_sent[i];
    end
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_dropped <= '0;
        else if (drop_o && r_dropped != '1) r_dropped <= r_dropped + 1'b1;
    end
    assign frames_dropped_o = r_dropped;
`endif
endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb_eth_tx_frame_arbiter: directed self-checking bench for eth_tx_frame_arbiter (2 requesters)
module tb_eth_tx_frame_arbiter;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [127:0] req_data;
    logic [1:0]   req_v, req_yumi, grant;
    logic [63:0]  fdata;
    logic         fv, fyumi, busy, drop;
`ifdef ETH_TX_ARB_STATS_EN
    logic [63:0]  sent;
    logic [31:0]  dropped;
`endif
    always #5 clk = ~clk;

    eth_tx_frame_arbiter dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .req_data_i       (req_data),
        .req_v_i          (req_v),
        .req_yumi_o       (req_yumi),
        .frame_data_o     (fdata),
        .frame_data_v_o   (fv),
        .frame_data_yumi_i(fyumi),
        .grant_o          (grant),
        .busy_o           (busy),
        .drop_o           (drop)
`ifdef ETH_TX_ARB_STATS_EN
        ,
        .frames_sent_o    (sent),
        .frames_dropped_o (dropped)
`endif
    );

    int total = 0, bad = 0;
    logic [63:0] q0[$], q1[$], out_q[$], exp_q[$];
    int pops0 = 0, pops1 = 0, drops = 0, viol = 0, pops_at_drop = 0, vcnt = 0;
    logic [1:0] grant_seen = 2'b00;
    logic [1:0] c_yumi;
    logic [63:0] c_d;
    logic c_v, c_fy, c_drop;

    function automatic logic [63:0] hdr(input int sz, input int off, input int tag);
        logic [15:0] s;
        logic [2:0]  o;
        logic [31:0] t;
        s = 16'(sz);
        o = 3'(off);
        t = 32'(tag);
        return {t, 13'h0aa, o, s};
    endfunction

    function automatic logic [63:0] pay(input int src, input int seq);
        return {8'hd0 + 8'(src), 56'(seq)};
    endfunction

    function automatic bit q_eq(input logic [63:0] a[$], input logic [63:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    // requester sources and TX sink: sample just before the edge, act just after it
    initial begin
        req_v    = 2'b00;
        req_data = '0;
        forever begin
            @(negedge clk);
            #3;
            c_yumi = req_yumi;
            c_v    = fv;
            c_d    = fdata;
            c_drop = drop;
            c_fy   = fyumi;
            if ((c_yumi & ~req_v) != 2'b00 || (c_yumi & ~grant) != 2'b00 ||
                (busy && !$onehot(grant)) || (!busy && grant != 2'b00) ||
                (fv && !busy) || (!busy && fdata != 64'd0))
                viol++;
            if (busy) grant_seen = grant_seen | grant;
            if (c_v) vcnt++;
            @(posedge clk);
            #1;
            if (c_yumi[0] && q0.size() > 0) begin q0.delete(0); pops0++; end
            if (c_yumi[1] && q1.size() > 0) begin q1.delete(0); pops1++; end
            if (c_v && c_fy) out_q.push_back(c_d);
            if (c_drop) begin drops++; pops_at_drop = pops0 + pops1; end
            req_v    = {q1.size() > 0, q0.size() > 0};
            req_data = {(q1.size() > 0) ? q1[0] : 64'd0, (q0.size() > 0) ? q0[0] : 64'd0};
        end
    end

    task automatic do_reset;
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        q0.delete(); q1.delete(); out_q.delete(); exp_q.delete();
        pops0 = 0; pops1 = 0; drops = 0; viol = 0; pops_at_drop = 0; vcnt = 0;
        grant_seen = 2'b00;
        fyumi = 1'b1;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while ((busy || q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, want idle", nm, budget);
        end
    endtask

    task automatic wait_out(input string nm, input int k, input int budget);
        int n;
        n = 0;
        while (out_q.size() < k && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d words, want %0d", nm, out_q.size(), k);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        fyumi   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant: got %b want 00", grant); end
        total++; if ({fv, drop, req_yumi} !== 4'b0000) begin bad++; $display("FAIL reset_strobes: got %b want 0000", {fv, drop, req_yumi}); end
        total++; if (fdata !== 64'd0) begin bad++; $display("FAIL reset_data: got %h want 0", fdata); end
        reset_n = 1'b1;
        fyumi   = 1'b1;
        q1.push_back(hdr(8, 0, 1)); q1.push_back(pay(1, 0));
        exp_q.push_back(hdr(8, 0, 1)); exp_q.push_back(pay(1, 0));
        @(negedge clk);
        #1;
        total++; if ({grant, req_yumi} !== 4'b0000) begin bad++; $display("FAIL grant_latency: grant/yumi got %b want 0000", {grant, req_yumi}); end
        @(negedge clk);
        #1;
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL first_grant: got %b want 10", grant); end
        wait_idle("reset_frame", 50);
        total++; if (!q_eq(out_q, exp_q)) begin bad++; $display("FAIL reset_frame_out: got %0d words want %0d", out_q.size(), exp_q.size()); end
    endtask

    task automatic test_single;
        do_reset();
        q0.push_back(hdr(60, 0, 16)); exp_q.push_back(hdr(60, 0, 16));
        for (int i = 0; i < 8; i++) begin q0.push_back(pay(0, i)); exp_q.push_back(pay(0, i)); end
        wait_idle("single", 100);
        total++; if (!q_eq(out_q, exp_q)) begin bad++; $display("FAIL single_out: got %0d words want 9", out_q.size()); end
        total++; if (grant_seen !== 2'b01) begin bad++; $display("FAIL single_grant: got %b want 01", grant_seen); end
        total++; if (pops0 !== 9 || drops !== 0) begin bad++; $display("FAIL single_counts: pops=%0d drops=%0d want 9 0", pops0, drops); end
        total++; if (viol !== 0) begin bad++; $display("FAIL single_rules: got %0d violations want 0", viol); end
`ifdef ETH_TX_ARB_STATS_EN
        total++; if (sent !== 64'd1) begin bad++; $display("FAIL single_stats: frames_sent got %h want 1", sent); end
`endif
    endtask

    task automatic test_contention;
        do_reset();
        q0.push_back(hdr(16, 0, 32)); q0.push_back(pay(0, 0)); q0.push_back(pay(0, 1));
        q1.push_back(hdr(24, 0, 33)); q1.push_back(pay(1, 0)); q1.push_back(pay(1, 1)); q1.push_back(pay(1, 2));
        exp_q = {hdr(16, 0, 32), pay(0, 0), pay(0, 1), hdr(24, 0, 33), pay(1, 0), pay(1, 1), pay(1, 2)};
        wait_idle("contention", 100);
        total++; if (!q_eq(out_q, exp_q)) begin bad++; $display("FAIL contention_order: got %0d words, order/content wrong or size want 7", out_q.size()); end
        total++; if (viol !== 0) begin bad++; $display("FAIL contention_rules: got %0d violations want 0", viol); end
        total++; if (grant_seen !== 2'b11) begin bad++; $display("FAIL contention_grants: got %b want 11", grant_seen); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        q0.push_back(hdr(8, 0, 48)); q0.push_back(pay(0, 0));
        q0.push_back(hdr(8, 0, 49)); q0.push_back(pay(0, 1));
        q1.push_back(hdr(8, 0, 50)); q1.push_back(pay(1, 0));
        exp_q = {hdr(8, 0, 48), pay(0, 0), hdr(8, 0, 50), pay(1, 0), hdr(8, 0, 49), pay(0, 1)};
        wait_idle("b2b", 100);
        total++; if (!q_eq(out_q, exp_q)) begin bad++; $display("FAIL b2b_fairness: got %0d words, order not r0,r1,r0", out_q.size()); end
        total++; if (viol !== 0) begin bad++; $display("FAIL b2b_rules: got %0d violations want 0", viol); end
    endtask

    task automatic test_offset;
        do_reset();
        q0.push_back(hdr(13, 5, 64)); exp_q.push_back(hdr(13, 5, 64));
        for (int i = 0; i < 3; i++) begin q0.push_back(pay(0, i)); exp_q.push_back(pay(0, i)); end
        q0.push_back(hdr(0, 0, 65));
        wait_idle("offset", 100);
        total++; if (!q_eq(out_q, exp_q)) begin bad++; $display("FAIL offset_beats: got %0d words want 4", out_q.size()); end
        total++; if (drops !== 1 || pops0 !== 5) begin bad++; $display("FAIL offset_tail: drops=%0d pops=%0d want 1 5", drops, pops0); end
    endtask

    task automatic test_zero;
        do_reset();
        q0.push_back(hdr(0, 0, 80)); q0.push_back(hdr(8, 0, 81)); q0.push_back(pay(0, 9));
        exp_q = {hdr(8, 0, 81), pay(0, 9)};
        wait_idle("zero", 100);
        total++; if (drops !== 1) begin bad++; $display("FAIL zero_drop: got %0d pulses want 1", drops); end
        total++; if (vcnt !== 2) begin bad++; $display("FAIL zero_valid: got %0d valid cycles want 2", vcnt); end
        total++; if (!q_eq(out_q, exp_q) || pops0 !== 3) begin bad++; $display("FAIL zero_next: got %0d words pops=%0d want 2 3", out_q.size(), pops0); end
    endtask

    task automatic test_oversize;
        do_reset();
        fyumi = 1'b0;
        q0.push_back(hdr(1600, 0, 96));
        for (int i = 0; i < 200; i++) q0.push_back(pay(0, i));
        wait_idle("oversize", 400);
        total++; if (out_q.size() !== 0 || vcnt !== 0) begin bad++; $display("FAIL oversize_fwd: got %0d words %0d valid want 0 0", out_q.size(), vcnt); end
        total++; if (pops0 !== 201) begin bad++; $display("FAIL oversize_drain: got %0d pops want 201", pops0); end
        total++; if (drops !== 1 || pops_at_drop !== 201) begin bad++; $display("FAIL oversize_drop: drops=%0d at_pop=%0d want 1 201", drops, pops_at_drop); end
`ifdef ETH_TX_ARB_STATS_EN
        total++; if (dropped !== 32'd1) begin bad++; $display("FAIL oversize_stats: frames_dropped got %0d want 1", dropped); end
`endif
    endtask

    task automatic test_stall_reset;
        int n, p;
        bit ok;
        do_reset();
        q0.push_back(hdr(60, 0, 112)); exp_q.push_back(hdr(60, 0, 112));
        for (int i = 0; i < 8; i++) begin q0.push_back(pay(0, i)); exp_q.push_back(pay(0, i)); end
        wait_out("stall_pre", 4, 50);
        fyumi = 1'b0;
        n = out_q.size();
        p = pops0;
        repeat (10) begin @(negedge clk); #1; end
        total++; if (out_q.size() !== n || pops0 !== p) begin bad++; $display("FAIL stall_hold: words %0d->%0d pops %0d->%0d want unchanged", n, out_q.size(), p, pops0); end
        total++; if (grant !== 2'b01 || busy !== 1'b1) begin bad++; $display("FAIL stall_grant: grant=%b busy=%b want 01 1", grant, busy); end
        fyumi = 1'b1;
        wait_out("stall_post", n + 2, 50);
        reset_n = 1'b0;
        #1;
        total++; if ({busy, grant, fv, drop, req_yumi} !== 7'd0 || fdata !== 64'd0) begin bad++; $display("FAIL midreset_outs: busy/grant/v/drop/yumi=%b data=%h want 0", {busy, grant, fv, drop, req_yumi}, fdata); end
        ok = (pops0 == out_q.size()) && (out_q.size() == n + 2);
        foreach (out_q[i]) if (out_q[i] !== exp_q[i]) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL stall_integrity: got %0d words pops=%0d want %0d in order", out_q.size(), pops0, n + 2); end
        q0.delete();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        total++; if (busy !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL postreset_idle: busy=%b grant=%b want 0 00", busy, grant); end
        total++; if (viol !== 0) begin bad++; $display("FAIL stall_rules: got %0d violations want 0", viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_offset();
        test_zero();
        test_oversize();
        test_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
